// File: rtl/ram_arbiter.sv
// Two-requester round-robin arbiter for the shared single-port SRAM.
// Each access walks SETUP -> STROBE -> DONE and drives the active-low CE/WE sequence.
`timescale 1ns/1ps
module ram_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic              WE0,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [0:DATA_W-1] WDATA0,
    input  logic [0:DATA_W-1] WDATA1,
    output logic              GNT0,
    output logic              GNT1,
    output logic              ACK0,
    output logic              ACK1,
    output logic [0:DATA_W-1] RDATA,
    output logic              BUSY,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic              RAM_CE_N,
    output logic              RAM_WE_N,
    output logic [0:DATA_W-1] RAM_DIN,
    output logic              RAM_DRIVE,
    input  logic [0:DATA_W-1] RAM_DOUT,
    output logic [1:0]        DBG_STATE
);

    // Handshake: a requester raises REQ with WE/ADDR/WDATA valid and keeps them
    // until GNT rises; ACK pulses for one cycle when the access completes, and
    // REQ must be low in the cycle after ACK unless another access is wanted.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic                own;
    logic                last;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [0:DATA_W-1]   wdata_q;
    logic [0:DATA_W-1]   rdata_q;

    logic                elig0;
    logic                elig1;
    logic                take;
    logic                win;

    // In DONE the current owner's REQ is masked so the other side gets a turn.
    always_comb begin
        elig0    = REQ0 && !(state == DONE && own == 1'b0);
        elig1    = REQ1 && !(state == DONE && own == 1'b1);
        take     = (state == IDLE || state == DONE) && (elig0 || elig1);
        win      = (elig0 && elig1) ? !last : elig1;
        state_nx = state;
        case (state)
            IDLE:    if (take) state_nx = SETUP;
            SETUP:   state_nx = STROBE;
            STROBE:  state_nx = DONE;
            DONE:    state_nx = take ? SETUP : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            own     <= 1'b0;
            last    <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (take) begin
                own     <= win;
                last    <= win;
                we_q    <= win ? WE1 : WE0;
                addr_q  <= win ? ADDR1 : ADDR0;
                wdata_q <= win ? WDATA1 : WDATA0;
            end
            if (state == STROBE && !we_q) begin
                rdata_q <= RAM_DOUT;
            end
        end
    end

    // All outputs decode registered state only, so grants and strobes are glitch-free.
    assign BUSY      = (state != IDLE);
    assign GNT0      = BUSY && (own == 1'b0);
    assign GNT1      = BUSY && (own == 1'b1);
    assign ACK0      = (state == DONE) && (own == 1'b0);
    assign ACK1      = (state == DONE) && (own == 1'b1);
    assign RDATA     = rdata_q;
    assign RAM_ADDR  = addr_q;
    assign RAM_DIN   = wdata_q;
    assign RAM_CE_N  = (state == IDLE);
    assign RAM_WE_N  = !((state == STROBE) && we_q);
    assign RAM_DRIVE = BUSY && we_q;
    assign DBG_STATE = state;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: behavioural SRAM, reference memory and
// per-requester expected queues scored on every ACK.
`timescale 1ns/1ps
module tb_ram_arbiter;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;

    logic              CLK;
    logic              RST;
    logic              REQ0, REQ1, WE0, WE1;
    logic [ADDR_W-1:0] ADDR0, ADDR1;
    logic [0:DATA_W-1] WDATA0, WDATA1;
    logic              GNT0, GNT1, ACK0, ACK1, BUSY;
    logic [0:DATA_W-1] RDATA;
    logic [ADDR_W-1:0] RAM_ADDR;
    logic              RAM_CE_N, RAM_WE_N, RAM_DRIVE;
    logic [0:DATA_W-1] RAM_DIN, RAM_DOUT;
    logic [1:0]        DBG_STATE;

    logic [0:DATA_W-1] mem     [0:(1<<ADDR_W)-1];
    logic [0:DATA_W-1] ref_mem [0:(1<<ADDR_W)-1];

    // Entry = {is_read, expected read data or written data}.
    logic [DATA_W:0] exp_q0[$];
    logic [DATA_W:0] exp_q1[$];
    int              ack_log[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc_cnt = 0;

    ram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
        .GNT0(GNT0), .GNT1(GNT1), .ACK0(ACK0), .ACK1(ACK1),
        .RDATA(RDATA), .BUSY(BUSY),
        .RAM_ADDR(RAM_ADDR), .RAM_CE_N(RAM_CE_N), .RAM_WE_N(RAM_WE_N),
        .RAM_DIN(RAM_DIN), .RAM_DRIVE(RAM_DRIVE), .RAM_DOUT(RAM_DOUT),
        .DBG_STATE(DBG_STATE)
    );

    // ---------------- clock / reset / SRAM model ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial forever begin
        @(posedge CLK);
        cyc_cnt++;
        if (!RAM_CE_N && !RAM_WE_N) mem[RAM_ADDR] = RAM_DIN;
    end

    assign RAM_DOUT = mem[RAM_ADDR];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] seed_word(input int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h6A5A0F0F;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_gnt0",  64'(GNT0),      64'd0);
        check_eq("rst_gnt1",  64'(GNT1),      64'd0);
        check_eq("rst_ack0",  64'(ACK0),      64'd0);
        check_eq("rst_ack1",  64'(ACK1),      64'd0);
        check_eq("rst_busy",  64'(BUSY),      64'd0);
        check_eq("rst_rdata", 64'(RDATA),     64'd0);
        check_eq("rst_addr",  64'(RAM_ADDR),  64'd0);
        check_eq("rst_din",   64'(RAM_DIN),   64'd0);
        check_eq("rst_ce_n",  64'(RAM_CE_N),  64'd1);
        check_eq("rst_we_n",  64'(RAM_WE_N),  64'd1);
        check_eq("rst_drive", 64'(RAM_DRIVE), 64'd0);
        check_eq("rst_state", 64'(DBG_STATE), 64'd0);
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        check_reset_outputs();
        RST = 1'b0;
    endtask

    // ---------------- driver ----------------
    // Raises REQ one cycle after call, waits for ACK, drops REQ in the ACK cycle.
    task automatic do_access(input int p, input logic we, input logic [ADDR_W-1:0] addr,
                             input logic [31:0] data, input bit solo,
                             output int lat, output int ack_at);
        int         n;
        logic [2:0] wen_mask;
        logic [2:0] ce_mask;
        logic       ack;
        @(posedge CLK); #1;
        if (we) ref_mem[addr] = data;
        if (p == 0) begin
            REQ0 = 1'b1; WE0 = we; ADDR0 = addr; WDATA0 = data;
            exp_q0.push_back({!we, we ? data : 32'(ref_mem[addr])});
        end else begin
            REQ1 = 1'b1; WE1 = we; ADDR1 = addr; WDATA1 = data;
            exp_q1.push_back({!we, we ? data : 32'(ref_mem[addr])});
        end
        n = 0; lat = -1; ack_at = -1; wen_mask = '0; ce_mask = '0;
        while (n < 20 && lat < 0) begin
            @(posedge CLK); #1;
            n++;
            if (n <= 3) begin
                wen_mask = {~RAM_WE_N, wen_mask[2:1]};
                ce_mask  = {~RAM_CE_N, ce_mask[2:1]};
            end
            ack = (p == 0) ? ACK0 : ACK1;
            if (ack) begin
                lat    = n;
                ack_at = cyc_cnt;
            end
        end
        if (lat < 0) check_eq($sformatf("ack%0d_timeout", p), 64'd1, 64'd0);
        if (solo) begin
            check_eq("wen_shape",  64'(wen_mask),  we ? 64'b010 : 64'b000);
            check_eq("ce_shape",   64'(ce_mask),   64'b111);
            check_eq("addr_hold",  64'(RAM_ADDR),  64'(addr));
            check_eq("drive_hold", 64'(RAM_DRIVE), 64'(we));
            if (we) check_eq("din_hold", 64'(RAM_DIN), 64'(data));
        end
        if (p == 0) REQ0 = 1'b0; else REQ1 = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    task automatic score_ack(input int p);
        logic [DATA_W:0] e;
        int              depth;
        depth = (p == 0) ? exp_q0.size() : exp_q1.size();
        if (depth == 0) begin
            check_eq($sformatf("ack%0d_unexpected", p), 64'd1, 64'd0);
        end else begin
            e = (p == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            if (e[DATA_W]) check_eq($sformatf("rdata%0d", p), 64'(RDATA), 64'(e[DATA_W-1:0]));
            ack_log.push_back(p);
        end
    endtask

    initial forever begin
        @(negedge CLK);
        if (BUSY) check_eq("gnt_exclusive", 64'(GNT0 & GNT1), 64'd0);
        if (ACK0) score_ack(0);
        if (ACK1) score_ack(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int lat0, lat1, at0, at1, prev_at, first_at, last_at;
        RST = 1'b1;
        REQ0 = 0; REQ1 = 0; WE0 = 0; WE1 = 0;
        ADDR0 = '0; ADDR1 = '0; WDATA0 = '0; WDATA1 = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem[i]     = seed_word(i);
            ref_mem[i] = seed_word(i);
        end
        repeat (2) @(posedge CLK);
        #1;
        check_reset_outputs();
        RST = 1'b0;

        // Simultaneous requests straight out of reset: requester 0 wins the tie.
        fork
            do_access(0, 1'b0, 15'h0030, 32'h0, 1'b0, lat0, at0);
            do_access(1, 1'b0, 15'h0031, 32'h0, 1'b0, lat1, at1);
        join
        check_eq("tie_lat0", 64'(lat0), 64'd3);
        check_eq("tie_lat1", 64'(lat1), 64'd6);

        // Single write then read, plus top-of-range address.
        do_access(0, 1'b1, 15'h0010, 32'h6A09E667, 1'b1, lat0, at0);
        check_eq("wr_lat", 64'(lat0), 64'd3);
        do_access(0, 1'b0, 15'h0010, 32'h0, 1'b1, lat0, at0);
        check_eq("rd_lat", 64'(lat0), 64'd3);
        do_access(0, 1'b1, 15'h7FFF, 32'hBB67AE85, 1'b1, lat0, at0);
        do_access(0, 1'b0, 15'h7FFF, 32'h0, 1'b1, lat0, at0);

        // Both requesters hold REQ for 6 accesses each.
        do_reset();
        ack_log.delete();
        first_at = -1; last_at = -1;
        fork
            begin
                int l, a;
                for (int i = 0; i < 6; i++) begin
                    do_access(0, 1'b1, 15'h0100 + 15'(i), $urandom, 1'b0, l, a);
                    if (i == 0) first_at = a;
                end
            end
            begin
                int l, a;
                for (int i = 0; i < 6; i++) begin
                    do_access(1, 1'b0, 15'h0200 + 15'(i), 32'h0, 1'b0, l, a);
                    if (i == 5) last_at = a;
                end
            end
        join
        @(negedge CLK);
        check_eq("alt_count", 64'(ack_log.size()), 64'd12);
        for (int i = 0; i < ack_log.size(); i++)
            check_eq($sformatf("alt_order_%0d", i), 64'(ack_log[i]), 64'(i % 2));
        check_eq("alt_span", 64'(last_at - first_at), 64'd33);

        // Requester 1 streams reads 0..71.
        prev_at = 0;
        for (int i = 0; i < 72; i++) begin
            do_access(1, 1'b0, 15'(i), 32'h0, 1'b1, lat1, at1);
            check_eq("stream_lat", 64'(lat1), 64'd3);
            if (i > 0) check_eq("stream_gap", 64'(at1 - prev_at), 64'd4);
            prev_at = at1;
        end

        // REQ1 raised during requester 0's SETUP cycle.
        fork
            do_access(0, 1'b0, 15'h0040, 32'h0, 1'b0, lat0, at0);
            begin
                @(posedge CLK);
                do_access(1, 1'b0, 15'h0041, 32'h0, 1'b0, lat1, at1);
            end
        join
        check_eq("pend_lat0", 64'(lat0), 64'd3);
        check_eq("pend_gap",  64'(at1 - at0), 64'd3);

        // Reset during the STROBE cycle of a write to 0x0020.
        @(posedge CLK); #1;
        REQ0 = 1'b1; WE0 = 1'b1; ADDR0 = 15'h0020; WDATA0 = 32'hDEADBEEF;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check_eq("abort_in_strobe", 64'(DBG_STATE), 64'd2);
        RST = 1'b1;
        @(posedge CLK); #1;
        check_reset_outputs();
        RST = 1'b0; REQ0 = 1'b0; WE0 = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        check_eq("abort_idle", 64'(BUSY), 64'd0);
        do_access(0, 1'b0, 15'h0021, 32'h0, 1'b1, lat0, at0);
        check_eq("after_abort_lat", 64'(lat0), 64'd3);

        repeat (2) @(negedge CLK);
        check_eq("q0_drained", 64'(exp_q0.size()), 64'd0);
        check_eq("q1_drained", 64'(exp_q1.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
